// File: rtl/nios_system_shmem_pkg.sv
// Shared definitions for the shared-memory stream reader and the RAM wrapper.
package nios_system_shmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StStatus
  } state_e;

  localparam int unsigned STATUS_DONE_BIT = 31;
  localparam logic [3:0]  MEM_BE_ALL      = 4'hF;
  localparam int unsigned SHMEM_DEPTH     = 1024;

endpackage

// File: rtl/shmem_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; rdata is valid whenever empty is low.
module shmem_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign do_push = push && (count_q != (PtrW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nios_system_shmem_stream_reader.sv
// Reads a word buffer from shared memory port 2, streams it as an Avalon-ST packet,
// then writes a completion status word back so the CPU can poll for consumption.
module nios_system_shmem_stream_reader
  import nios_system_shmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [ADDR_W-1:0] status_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, status_q;
  logic [LEN_W-1:0]  len_q, issued_q, len_in;
  logic              inflight_q, done_q;
  logic [1:0]        tag_q;
  logic              issue, room, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [DATA_W+1:0] fifo_rdata;
  logic [DATA_W-1:0] status_word;

  assign len_in = (len_words > MaxLen) ? MaxLen : len_words;

  // In-flight reads reserve FIFO space so returning data always has a slot.
  assign room  = ({1'b0, fifo_count} + (CntW+1)'(inflight_q)) < (CntW+1)'(FIFO_DEPTH);
  assign issue = (state_q == StRead) && (issued_q != len_q) && room;

  always_comb begin
    status_word = '0;
    status_word[LEN_W-1:0] = len_q;
    status_word[STATUS_DONE_BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (len_words == '0) ? StStatus : StRead;
      StRead:   if (issue && (issued_q + LEN_W'(1) == len_q)) state_d = StDrain;
      StDrain:  if (fifo_empty && !inflight_q) state_d = StStatus;
      StStatus: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_address    = '0;
    mem_writedata  = '0;
    unique case (state_q)
      StRead: if (issue) begin
        mem_chipselect = 1'b1;
        mem_byteenable = MEM_BE_ALL;
        mem_address    = base_q + issued_q[ADDR_W-1:0];
      end
      StStatus: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = MEM_BE_ALL;
        mem_address    = status_q;
        mem_writedata  = status_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q     <= '0;
      status_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= (state_q == StStatus);
      inflight_q <= issue;
      if (state_q == StIdle && start) begin
        base_q   <= base_addr;
        status_q <= status_addr;
        len_q    <= len_in;
        issued_q <= '0;
      end
      if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
        // {eop, sop} travel with the read so they line up with the returning word.
        tag_q    <= {issued_q == len_q - LEN_W'(1), issued_q == '0};
      end
    end
  end

  shmem_sync_fifo #(
    .WIDTH(DATA_W + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (inflight_q),
    .wdata  ({tag_q, mem_readdata}),
    .pop    (st_valid && st_ready),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign st_valid  = !fifo_empty;
  assign {st_eop, st_sop, st_data} = st_valid ? fifo_rdata : '0;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign mem_clken = 1'b1;

endmodule

// File: tb/tb_nios_system_shmem_stream_reader.sv
// Scoreboard bench for the shared-memory stream reader with a 1-cycle-latency RAM model.
module tb_nios_system_shmem_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len_words;
  logic [9:0]  status_addr;
  logic        busy, done;
  logic [9:0]  mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic [31:0] st_data;
  logic        st_valid, st_ready, st_sop, st_eop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nios_system_shmem_stream_reader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .len_words     (len_words),
    .status_addr   (status_addr),
    .busy          (busy),
    .done          (done),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_writedata (mem_writedata),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata),
    .st_data       (st_data),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_sop        (st_sop),
    .st_eop        (st_eop)
  );

  // RAM model: preloaded on the first clock, registered read data.
  logic [31:0] ram [1024];
  logic        preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 + 32'(i);
      preloaded <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [9:0]  exp_rd[$];
  logic [33:0] exp_beat[$];
  logic [41:0] exp_wr[$];

  int rd_issued = 0;
  int beats_popped = 0;
  int done_count = 0;
  logic        stall_prev = 1'b0;
  logic [33:0] stall_word;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_chipselect && !mem_write) begin
        rd_issued++;
        if (exp_rd.size() == 0) check("unexpected_read", 64'(mem_address), 64'hFFFF);
        else check("read_addr", 64'(mem_address), 64'(exp_rd.pop_front()));
        check("read_be", 64'(mem_byteenable), 64'hF);
        check("outstanding_le_depth", 64'((rd_issued - beats_popped) <= 4), 64'd1);
      end
      if (mem_chipselect && mem_write) begin
        if (exp_wr.size() == 0) check("unexpected_write", 64'(mem_address), 64'hFFFF);
        else check("status_write", {22'd0, mem_address, mem_writedata}, 64'(exp_wr.pop_front()));
        check("write_be", 64'(mem_byteenable), 64'hF);
      end
      if (stall_prev)
        check("stall_hold", 64'({st_valid, st_eop, st_sop, st_data}), 64'({1'b1, stall_word}));
      stall_prev = st_valid && !st_ready;
      stall_word = {st_eop, st_sop, st_data};
      if (st_valid && st_ready) begin
        beats_popped++;
        if (exp_beat.size() == 0) check("unexpected_beat", 64'({st_eop, st_sop, st_data}), 64'h0);
        else check("beat", 64'({st_eop, st_sop, st_data}), 64'(exp_beat.pop_front()));
      end
      if (done) done_count++;
    end else begin
      rd_issued    = 0;
      beats_popped = 0;
      stall_prev   = 1'b0;
    end
  end

  // st_ready driver: always 1, or pattern 1,0,0,1 repeating.
  logic       ready_mode = 1'b0;
  logic [3:0] ready_pat = 4'b1001;
  initial begin
    int cyc = 0;
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      st_ready = ready_mode ? ready_pat[cyc % 4] : 1'b1;
      cyc++;
    end
  end

  task automatic chk_reset_outputs(input string name);
    check(name, 64'({busy, done, st_valid, mem_chipselect, mem_write, mem_byteenable, mem_address,
                     st_sop, st_eop, mem_clken}), 64'h1);
    check({name, "_data"}, {mem_writedata, st_data}, 64'h0);
  endtask

  task automatic issue_cmd(input int base, input int len, input int status, input bit measure);
    int lat;
    for (int i = 0; i < len; i++) begin
      logic [9:0] a;
      a = 10'((base + i) % 1024);
      exp_rd.push_back(a);
      exp_beat.push_back({i == len - 1, i == 0, 32'hA500_0000 + 32'(a)});
    end
    exp_wr.push_back({10'(status), 32'h8000_0000 | 32'(len)});
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'(base); len_words = 11'(len); status_addr = 10'(status);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    if (measure) begin
      lat = 99;
      for (int c = 1; c < 10; c++) begin
        @(negedge clk);
        if (st_valid) begin
          lat = c;
          break;
        end
      end
      check("first_valid_latency", 64'(lat), 64'd3);
    end
  endtask

  task automatic finish_cmd(input int d0);
    bit seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_count - d0), 64'd1);
    check("queues_empty", 64'(exp_rd.size() + exp_beat.size() + exp_wr.size()), 64'd0);
  endtask

  initial begin
    int d0;
    int b0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; len_words = '0; status_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    d0 = done_count; issue_cmd(16, 4, 100, 1'b1); finish_cmd(d0);
    check("status_mem_100", 64'(ram[100]), 64'h8000_0004);

    d0 = done_count; issue_cmd(1022, 4, 200, 1'b0); finish_cmd(d0);
    check("status_mem_200", 64'(ram[200]), 64'h8000_0004);

    ready_mode = 1'b1;
    d0 = done_count; issue_cmd(300, 8, 201, 1'b0); finish_cmd(d0);
    ready_mode = 1'b0;
    check("status_mem_201", 64'(ram[201]), 64'h8000_0008);

    d0 = done_count; issue_cmd(5, 0, 202, 1'b0); finish_cmd(d0);
    check("status_mem_202", 64'(ram[202]), 64'h8000_0000);

    d0 = done_count; issue_cmd(40, 1, 203, 1'b0); finish_cmd(d0);
    check("status_mem_203", 64'(ram[203]), 64'h8000_0001);

    // Abort mid-packet with reset after two accepted beats.
    d0 = done_count;
    b0 = beats_popped;
    issue_cmd(50, 6, 204, 1'b0);
    for (int c = 0; c < 100 && beats_popped < b0 + 2; c++) @(posedge clk);
    check("two_beats_before_reset", 64'(beats_popped - b0 >= 2), 64'd1);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    exp_rd.delete(); exp_beat.delete(); exp_wr.delete();
    @(negedge clk);
    chk_reset_outputs("abort_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_status_after_abort", 64'(ram[204]), 64'hA500_00CC);
    check("no_done_after_abort", 64'(done_count - d0), 64'd0);

    d0 = done_count; issue_cmd(60, 3, 205, 1'b0); finish_cmd(d0);
    check("status_mem_205", 64'(ram[205]), 64'h8000_0003);

    // A start while busy must be ignored.
    d0 = done_count;
    issue_cmd(70, 5, 206, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'd400; len_words = 11'd2; status_addr = 10'd207;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_cmd(d0);
    check("status_mem_206", 64'(ram[206]), 64'h8000_0005);
    check("ignored_start_no_write", 64'(ram[207]), 64'hA500_00CF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
